// File: rtl/spi_adc_pkg.sv
// Shared definitions for the ADC-side SPI serializer: FSM encoding,
// synchroniser depth and the counter-width helper.
package spi_adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned SYNC_STAGES = 2;

    // Bits needed to count 0 .. value-1 (minimum 1).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        if (result == 0) result = 1;
        return result;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with a show-ahead head register: pop_data already
// holds the oldest entry whenever empty is low.
module sample_fifo #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr_next;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] head_next;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = head_q;

    // The head follows the pushed word only when nothing older survives this cycle.
    always_comb begin
        rd_ptr_next = do_pop ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
        head_next   = head_q;
        if (do_push && (empty || (count == (ADDR_WIDTH+1)'(1) && do_pop)))
            head_next = push_data;
        else if (do_pop)
            head_next = mem[rd_ptr_next];
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            rd_ptr <= rd_ptr_next;
            head_q <= head_next;
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_adc_transmitter.sv
// SPI slave serializer standing in for the ADC: buffers stream samples and
// shifts one per chip-select frame MSB-first on spi_data.
module spi_adc_transmitter
    import spi_adc_pkg::*;
#(
    parameter int unsigned             SAMPLE_WIDTH    = 12,
    parameter int unsigned             FRAME_BITS      = 16,
    parameter int unsigned             FIFO_ADDR_WIDTH = 2,
    parameter logic [SAMPLE_WIDTH-1:0] IDLE_WORD       = '0,
    parameter int unsigned             COUNT_WIDTH     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    spi_clock,
    input  logic                    spi_chipselect,
    output logic                    spi_data,
    output logic [COUNT_WIDTH-1:0]  frame_count,
    output logic [COUNT_WIDTH-1:0]  underrun_count
);

    localparam int unsigned BIT_CNT_WIDTH = clogb2(FRAME_BITS);
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic                    sclk_hist;
    logic                    cs_hist;
    logic                    sclk_s;
    logic                    cs_s;
    logic                    sclk_rise;
    logic                    sclk_fall;
    logic                    cs_rise;
    logic                    cs_fall;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic [SAMPLE_WIDTH-1:0] fifo_data;
    logic                    fifo_full;
    logic                    fifo_empty;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [FRAME_BITS-1:0]   frame_word;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;

    assign sample_ready = !fifo_full;
    assign fifo_push    = sample_valid && sample_ready;
    assign fifo_pop     = (state == IDLE) && cs_fall && !fifo_empty;

    sample_fifo #(
        .DATA_WIDTH (SAMPLE_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_sample_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (sample_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Idle levels on reset keep a quiet bus from looking like an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clock};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_chipselect};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            cs_hist   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = !sclk_hist && sclk_s;
    assign sclk_fall = sclk_hist && !sclk_s;
    assign cs_rise   = !cs_hist && cs_s;
    assign cs_fall   = cs_hist && !cs_s;

    assign frame_word = FRAME_BITS'(fifo_empty ? IDLE_WORD : fifo_data);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            spi_data       <= 1'b0;
            shift_reg      <= '0;
            bit_cnt        <= '0;
            frame_count    <= '0;
            underrun_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    spi_data <= 1'b0;
                    if (cs_fall) begin
                        state     <= SHIFT;
                        shift_reg <= frame_word;
                        spi_data  <= frame_word[FRAME_BITS-1];
                        bit_cnt   <= '0;
                        if (fifo_empty && underrun_count != '1)
                            underrun_count <= underrun_count + COUNT_WIDTH'(1);
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        spi_data <= 1'b0;
                    end else if (sclk_rise && bit_cnt == LAST_BIT) begin
                        frame_count <= frame_count + COUNT_WIDTH'(1);
                    end else if (sclk_fall) begin
                        if (bit_cnt == LAST_BIT) begin
                            state    <= DONE;
                            spi_data <= 1'b0;
                        end else begin
                            shift_reg <= shift_reg << 1;
                            spi_data  <= shift_reg[FRAME_BITS-2];
                            bit_cnt   <= bit_cnt + BIT_CNT_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    spi_data <= 1'b0;
                    if (cs_rise) state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    spi_data <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_adc_transmitter.sv
// Directed bench: acts as the SPI master and the sample source, comparing
// captured frames and status counters against hand-computed values.
module tb_spi_adc_transmitter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reset_sat = 1'b1;
    logic [11:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        spi_clock = 1'b0;
    logic        spi_chipselect = 1'b1;
    logic        spi_data;
    logic [15:0] frame_count;
    logic [15:0] underrun_count;

    logic        sample_ready_sat;
    logic        spi_data_sat;
    logic [1:0]  frame_count_sat;
    logic [1:0]  underrun_count_sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    spi_adc_transmitter #(
        .SAMPLE_WIDTH    (12),
        .FRAME_BITS      (16),
        .FIFO_ADDR_WIDTH (2),
        .IDLE_WORD       (12'h800),
        .COUNT_WIDTH     (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .spi_clock      (spi_clock),
        .spi_chipselect (spi_chipselect),
        .spi_data       (spi_data),
        .frame_count    (frame_count),
        .underrun_count (underrun_count)
    );

    // Narrow counters so saturation and wrap are reachable in a few frames.
    spi_adc_transmitter #(
        .SAMPLE_WIDTH    (12),
        .FRAME_BITS      (16),
        .FIFO_ADDR_WIDTH (2),
        .IDLE_WORD       (12'h000),
        .COUNT_WIDTH     (2)
    ) dut_sat (
        .clock          (clock),
        .reset          (reset_sat),
        .sample_data    (12'h000),
        .sample_valid   (1'b0),
        .sample_ready   (sample_ready_sat),
        .spi_clock      (spi_clock),
        .spi_chipselect (spi_chipselect),
        .spi_data       (spi_data_sat),
        .frame_count    (frame_count_sat),
        .underrun_count (underrun_count_sat)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_sample(input logic [11:0] value);
        sample_data  = value;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
    endtask

    // Drops CS and runs n SCLK periods (5 clocks per phase), capturing on each rise.
    task automatic start_frame(input int n_rises, output logic [15:0] word);
        word = '0;
        spi_chipselect = 1'b0;
        tick(5);
        for (int i = 0; i < n_rises; i++) begin
            word = {word[14:0], spi_data};
            spi_clock = 1'b1;
            tick(5);
            spi_clock = 1'b0;
            tick(5);
        end
    endtask

    task automatic end_frame();
        spi_chipselect = 1'b1;
        tick(8);
    endtask

    task automatic full_frame(output logic [15:0] word);
        start_frame(16, word);
        end_frame();
    endtask

    initial begin
        logic [15:0] word;
        int          accepted;
        logic [15:0] expected_word;

        tick(5);
        reset     = 1'b0;
        reset_sat = 1'b0;
        tick(1);
        check("reset_ready", sample_ready, 1);
        check("reset_spi_data", spi_data, 0);
        check("reset_frame_count", frame_count, 0);
        check("reset_underrun", underrun_count, 0);

        // SCLK activity with CS high must not disturb anything.
        for (int i = 0; i < 3; i++) begin
            spi_clock = 1'b1; tick(5);
            spi_clock = 1'b0; tick(5);
        end
        check("sclk_cs_high_spi_data", spi_data, 0);

        push_sample(12'hABC);
        check("single_ready", sample_ready, 1);
        full_frame(word);
        check("single_word", word, 16'h0ABC);
        check("single_frame_count", frame_count, 1);
        check("single_underrun", underrun_count, 0);
        check("single_ready_after", sample_ready, 1);

        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            sample_valid = (accepted < 5);
            sample_data  = 12'(accepted + 1);
            if (sample_valid && sample_ready) accepted++;
            tick(1);
        end
        sample_valid = 1'b0;
        check("fill_accepted", accepted, 4);
        check("fill_ready_full", sample_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            full_frame(word);
            expected_word = 16'(i);
            check("fill_order", word, expected_word);
        end
        check("fill_frame_count", frame_count, 5);
        check("fill_ready_drained", sample_ready, 1);

        full_frame(word);
        check("underrun_word", word, 16'h0800);
        check("underrun_count", underrun_count, 1);
        check("underrun_frame_count", frame_count, 6);

        push_sample(12'h123);
        start_frame(6, word);
        spi_chipselect = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("abort_spi_data", spi_data, 0);
        @(negedge clock);
        tick(8);
        check("abort_frame_count", frame_count, 6);
        full_frame(word);
        check("abort_next_word", word, 16'h0800);
        check("abort_next_underrun", underrun_count, 2);
        check("abort_next_frame_count", frame_count, 7);

        push_sample(12'hFFF);
        push_sample(12'h5A5);
        push_sample(12'h3C3);
        start_frame(9, word);
        check("midframe_bit9", spi_data, 1);
        reset          = 1'b1;
        spi_chipselect = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midreset_spi_data", spi_data, 0);
        check("midreset_ready", sample_ready, 1);
        check("midreset_frame_count", frame_count, 0);
        check("midreset_underrun", underrun_count, 0);
        tick(8);
        full_frame(word);
        check("postreset_word", word, 16'h0800);
        check("postreset_underrun", underrun_count, 1);
        check("postreset_frame_count", frame_count, 1);

        reset_sat = 1'b1;
        tick(1);
        reset_sat = 1'b0;
        tick(2);
        for (int k = 1; k <= 5; k++) begin
            full_frame(word);
            check("sat_word", word, 16'h0800);
            check("sat_underrun", underrun_count_sat, (k < 3) ? k : 3);
            check("sat_frame_wrap", frame_count_sat, k % 4);
        end
        check("sat_main_underrun", underrun_count, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_adc_transmitter.md
Name: spi_adc_transmitter

Overview:
ADC-side end of the sample SPI link: a serializer that models the converter which the sample-capture master reads from. It accepts samples on a valid/ready stream and buffers them in a small FIFO. It then shifts each sample out MSB-first on spi_data, framed by the master's spi_chipselect and spi_clock. It serves as the synthesizable stand-in ADC for loopback builds and as the driver in the capture-path benches.

Parameters:
SAMPLE_WIDTH, 12, bits per sample taken from the input stream.
FRAME_BITS, 16, SPI clocks per frame; must be >= SAMPLE_WIDTH.
FIFO_ADDR_WIDTH, 2, FIFO depth = 2**FIFO_ADDR_WIDTH entries.
IDLE_WORD, 0, SAMPLE_WIDTH-bit value sent when the FIFO is empty at frame start.
COUNT_WIDTH, 16, width of the status counters.

Ports:
clock  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
sample_data  in  SAMPLE_WIDTH  sample to transmit.
sample_valid  in  1  sample_data is valid.
sample_ready  out  1  FIFO can accept a sample.
spi_clock  in  1  SCLK from the master; asynchronous to clock.
spi_chipselect  in  1  active-low frame select from the master; asynchronous.
spi_data  out  1  serial data (MISO).
frame_count  out  COUNT_WIDTH  completed frames, wrapping.
underrun_count  out  COUNT_WIDTH  frames started with an empty FIFO, saturating.

Behaviour:
Reset:
- FIFO emptied; sample_ready=1; spi_data=0; both counters=0; state=IDLE.
- Reset asserted mid-frame aborts the frame immediately; spi_data=0 on the cycle after reset is sampled.

Input synchronisation:
- spi_clock and spi_chipselect pass through two-flop synchronisers, plus one history flop for edge detection.
- Edge-to-action latency is 3 clocks.
- Requirement: each SCLK phase lasts >= 4 clock periods.

FIFO:
- sample_ready = !full.
- Push when sample_valid && sample_ready.
- Pop only at frame start.
- Push and pop in the same cycle are both honoured.
- No bypass: a push into an empty FIFO in the same cycle as a frame start does not feed that frame; the frame counts as an underrun.

Frame word:
- {(FRAME_BITS-SAMPLE_WIDTH) zeros, sample}, shifted MSB-first.

State machine:
- IDLE: spi_data=0. On a synchronised CS falling edge, go to SHIFT:
  - load the frame word from a FIFO pop, or from IDLE_WORD if the FIFO is empty (underrun_count++, saturating at all-ones);
  - drive the frame MSB on spi_data;
  - bit_cnt=0.
- SHIFT: on each synchronised SCLK falling edge:
  - shift left and drive the next bit; bit_cnt++;
  - the master samples on SCLK rising edges;
  - after the falling edge that follows the FRAME_BITS-th rising edge, go to DONE and drive spi_data=0.
- SHIFT, alternative: when bit_cnt==FRAME_BITS-1 and the FRAME_BITS-th rising edge occurs, frame_count++ (wrapping); the frame counts as complete.
- DONE: spi_data=0. Extra SCLK edges are ignored. CS rising edge -> IDLE.
- CS rising edge in SHIFT before the frame completes: abort to IDLE, spi_data=0, frame_count unchanged. The popped sample is discarded, not restored.
- CS falling and SCLK edge detected in the same cycle: the CS edge wins; the SCLK edge is ignored.
- SCLK edges while CS is high: ignored.

Decomposition:
- Shared package spi_adc_pkg holds:
  - state encoding (IDLE, SHIFT, DONE);
  - the synchroniser depth constant (2);
  - a clogb2 function for bit_cnt width = clogb2(FRAME_BITS).
- One natural sub-module: sample_fifo, parameterised by data width and address width.
  - Interface: push/pop/full/empty; registered output.
  - Read data valid on the same cycle as pop, via a show-ahead head register.

Test Plan:
- Push 0xABC, then run one 16-clock frame (SCLK phase 5 clocks) -> master captures 0x0ABC; frame_count=1; underrun_count=0; sample_ready stays 1.
- Hold sample_valid=1 with 5 samples and no frames -> 4 accepted; sample_ready=0 after the 4th; frames then return the samples in order 1,2,3,4.
- Start a frame with an empty FIFO and IDLE_WORD=0x800 -> captured word 0x0800; underrun_count=1; frame_count=1.
- Push 0x123, then raise CS after 6 SCLK rising edges -> spi_data=0 within 3 clocks; frame_count=0; the next frame sends the next sample or an underrun, never 0x123.
- Assert reset at bit 9 of a frame with 3 samples queued -> the cycle after reset: spi_data=0, sample_ready=1, counters=0; the next frame is an underrun.
- Force underrun_count to 0xFFFE, then run 3 empty frames -> the counter saturates at 0xFFFF.
